read_channels_subo_p: RTL

Parametrised AXI-style read subordinate that terminates the AR and R channels of a bus port and bridges them to the memory-side request/line interface. It buffers up to RQ_DEPTH read requests, forwards them downstream with a valid/ready handshake, and serialises each returned LINE_W-bit line into LINE_W/DATA_W R beats with rlast on the final beat. It generalises the fixed 4-bit-ID, 32-bit-beat, 128-bit-line read channel pair, and replaces the single `qfull_1` back-pressure signal with an internal request FIFO.

---
 rtl/read_channels_subo_p_if.sv | 40 ++++
 rtl/read_channels_subo_p.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/read_channels_subo_p_if.sv
// Bus bundle for the read subordinate: AR/R towards the bus master, request/line towards memory.
// The slave modport is the subordinate's view; the master modport is the surrounding system.
interface read_channels_subo_p_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rreqc_s_valid;
  logic              rreqc_s_ready;
  logic [ID_W-1:0]   rreqc_s_id;
  logic [ADDR_W-1:0] rreqc_s_addr;
  logic              rdata_s_valid;
  logic [ID_W-1:0]   rdata_s_id;
  logic [LINE_W-1:0] rdata_s_data;
  logic              finish_rdata_s;

  modport slave (
    input  arvalid, arid, araddr, rready, rreqc_s_ready,
           rdata_s_valid, rdata_s_id, rdata_s_data,
    output arready, rvalid, rid, rdata, rlast,
           rreqc_s_valid, rreqc_s_id, rreqc_s_addr, finish_rdata_s
  );

  modport master (
    output arvalid, arid, araddr, rready, rreqc_s_ready,
           rdata_s_valid, rdata_s_id, rdata_s_data,
    input  arready, rvalid, rid, rdata, rlast,
           rreqc_s_valid, rreqc_s_id, rreqc_s_addr, finish_rdata_s
  );
endinterface

// File: rtl/read_channels_subo_p.sv
// Read subordinate: queues AR requests in a FIFO for memory and serialises returned lines into R beats.
// Optional RCH_FAST_START_EN presents beat 0 straight from the memory side while idle.
module read_channels_subo_p #(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LINE_W   = 128,
  parameter int RQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  read_channels_subo_p_if.slave bus
);
  localparam int BEATS = LINE_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = $clog2(RQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [ID_W-1:0]   fifo_id   [RQ_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [RQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign push  = bus.arvalid && !full;
  assign pop   = bus.rreqc_s_ready && !empty;

  assign bus.arready       = !full;
  assign bus.rreqc_s_valid = !empty;
  assign bus.rreqc_s_id    = fifo_id[rd_ptr[IDX_W-1:0]];
  assign bus.rreqc_s_addr  = fifo_addr[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RQ_DEPTH; i++) begin
        fifo_id[i]   <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_id[wr_ptr[IDX_W-1:0]]   <= bus.arid;
        fifo_addr[wr_ptr[IDX_W-1:0]] <= bus.araddr;
        wr_ptr                       <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  typedef enum logic [1:0] {IDLE, SEND, DONE} r_state_t;

  r_state_t                     state;
  logic [BEATS-1:0][DATA_W-1:0] line_q;
  logic [CNT_W-1:0]             cnt;
  logic [ID_W-1:0]              rid_q;
  logic                         rvalid_q;
  logic                         rlast_q;
  logic                         finish_q;

  assign bus.finish_rdata_s = finish_q;

`ifdef RCH_FAST_START_EN
  logic fast_idle;
  assign fast_idle  = (state == IDLE) && bus.rdata_s_valid;
  assign bus.rvalid = rvalid_q || fast_idle;
  assign bus.rid    = fast_idle ? bus.rdata_s_id : rid_q;
  assign bus.rdata  = fast_idle ? bus.rdata_s_data[DATA_W-1:0] : line_q[cnt];
  assign bus.rlast  = rlast_q || (fast_idle && (LAST_BEAT == '0));
`else
  assign bus.rvalid = rvalid_q;
  assign bus.rid    = rid_q;
  assign bus.rdata  = line_q[cnt];
  assign bus.rlast  = rlast_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      line_q   <= '0;
      cnt      <= '0;
      rid_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.rdata_s_valid) begin
            line_q <= bus.rdata_s_data;
            rid_q  <= bus.rdata_s_id;
`ifdef RCH_FAST_START_EN
            // Beat 0 was already offered combinationally this cycle.
            if (bus.rready && (LAST_BEAT == '0)) begin
              state    <= DONE;
              cnt      <= '0;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              finish_q <= 1'b1;
            end else if (bus.rready) begin
              state    <= SEND;
              cnt      <= CNT_W'(1);
              rvalid_q <= 1'b1;
              rlast_q  <= (LAST_BEAT == CNT_W'(1));
            end else begin
              state    <= SEND;
              cnt      <= '0;
              rvalid_q <= 1'b1;
              rlast_q  <= (LAST_BEAT == '0);
            end
`else
            state    <= SEND;
            cnt      <= '0;
            rvalid_q <= 1'b1;
            rlast_q  <= (LAST_BEAT == '0);
`endif
          end
        end
        SEND: begin
          if (bus.rready) begin
            if (cnt == LAST_BEAT) begin
              state    <= DONE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              finish_q <= 1'b1;
            end else begin
              cnt     <= cnt + CNT_W'(1);
              rlast_q <= ((cnt + CNT_W'(1)) == LAST_BEAT);
            end
          end
        end
        DONE: begin
          finish_q <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
